pi_ctrl_axil_regs: RTL and testbench



---
 rtl/pi_ctrl_axil_regs.sv | 203 ++++++++++++++++++++
 tb/tb_pi_ctrl_axil_regs.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pi_ctrl_axil_regs.sv
// AXI4-Lite slave holding the four PI controller gain/setpoint words.
// Independent write and read channel FSMs; one outstanding transfer per channel.
//
// state  | meaning
// W_IDLE | collecting AW and W (either order); commit once both are held
// W_RESP | write applied, BVALID asserted until BREADY
// R_IDLE | ARREADY high, waiting for an AR handshake
// R_DATA | RVALID/RDATA held until RREADY
module pi_ctrl_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg0_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg1_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg2_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg3_o,
  output logic [3:0]                      reg_wr_pulse_o
);

  typedef enum logic {W_IDLE, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_DATA} rstate_e;

  wstate_e wstate_q, wstate_d;
  rstate_e rstate_q, rstate_d;

  logic [3:0][C_S_AXI_DATA_WIDTH-1:0] regs_q, regs_d;
  logic                               aw_held_q, aw_held_d;
  logic                               w_held_q, w_held_d;
  logic [1:0]                         awidx_q, awidx_d;
  logic [C_S_AXI_DATA_WIDTH-1:0]      wdata_q, wdata_d;
  logic [C_S_AXI_DATA_WIDTH/8-1:0]    wstrb_q, wstrb_d;
  logic                               awready_q, awready_d;
  logic                               wready_q, wready_d;
  logic                               bvalid_q, bvalid_d;
  logic [3:0]                         pulse_q, pulse_d;
  logic                               arready_q, arready_d;
  logic                               rvalid_q, rvalid_d;
  logic [C_S_AXI_DATA_WIDTH-1:0]      rdata_q, rdata_d;

  logic aw_hs, w_hs, ar_hs;
  logic unused_ok;

  assign aw_hs = S_AXI_AWVALID & awready_q;
  assign w_hs  = S_AXI_WVALID & wready_q;
  assign ar_hs = S_AXI_ARVALID & arready_q;

  // Protection bits and byte offset within a word carry no meaning here.
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  always_comb begin
    wstate_d  = wstate_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awidx_d   = awidx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    regs_d    = regs_q;
    pulse_d   = '0;
    case (wstate_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          awidx_d   = S_AXI_AWADDR[3:2];
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = S_AXI_WDATA;
          wstrb_d  = S_AXI_WSTRB;
        end
        // The _d copies already reflect a handshake landing on this edge.
        if (aw_held_d && w_held_d) begin
          for (int k = 0; k < C_S_AXI_DATA_WIDTH / 8; k++) begin
            if (wstrb_d[k]) regs_d[awidx_d][8*k +: 8] = wdata_d[8*k +: 8];
          end
          pulse_d[awidx_d] = 1'b1;
          bvalid_d  = 1'b1;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          wstate_d  = W_RESP;
        end else begin
          awready_d = ~aw_held_d;
          wready_d  = ~w_held_d;
        end
      end
      W_RESP: begin
        awready_d = 1'b0;
        wready_d  = 1'b0;
        if (S_AXI_BREADY) begin
          bvalid_d  = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          wstate_d  = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    rstate_d  = rstate_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    case (rstate_q)
      R_IDLE: begin
        arready_d = 1'b1;
        // Sampling regs_q gives the pre-write value on a same-edge commit.
        if (ar_hs) begin
          rdata_d   = regs_q[S_AXI_ARADDR[3:2]];
          rvalid_d  = 1'b1;
          arready_d = 1'b0;
          rstate_d  = R_DATA;
        end
      end
      R_DATA: begin
        arready_d = 1'b0;
        if (S_AXI_RREADY) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          rstate_d  = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wstate_q  <= W_IDLE;
      rstate_q  <= R_IDLE;
      regs_q    <= '0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awidx_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      pulse_q   <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      wstate_q  <= wstate_d;
      rstate_q  <= rstate_d;
      regs_q    <= regs_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awidx_q   <= awidx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      pulse_q   <= pulse_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

  assign S_AXI_AWREADY  = awready_q;
  assign S_AXI_WREADY   = wready_q;
  assign S_AXI_BVALID   = bvalid_q;
  assign S_AXI_BRESP    = 2'b00;
  assign S_AXI_ARREADY  = arready_q;
  assign S_AXI_RVALID   = rvalid_q;
  assign S_AXI_RDATA    = rdata_q;
  assign S_AXI_RRESP    = 2'b00;
  assign reg0_o         = regs_q[0];
  assign reg1_o         = regs_q[1];
  assign reg2_o         = regs_q[2];
  assign reg3_o         = regs_q[3];
  assign reg_wr_pulse_o = pulse_q;

endmodule

// File: tb/tb_pi_ctrl_axil_regs.sv
// Bench for pi_ctrl_axil_regs: directed AXI4-Lite scenarios followed by random
// traffic, checked against an array model of the four registers.
module tb_pi_ctrl_axil_regs;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [3:0]  awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [3:0]  araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [31:0] reg0, reg1, reg2, reg3;
  logic [3:0]  pulse;

  int tests = 0;
  int fails = 0;
  logic [31:0] model [4];

  always #5 aclk = ~aclk;

  pi_ctrl_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
    .ACLK(aclk), .ARESET(areset),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg0_o(reg0), .reg1_o(reg1), .reg2_o(reg2), .reg3_o(reg3),
    .reg_wr_pulse_o(pulse)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dut_reg(input int i);
    case (i)
      0: return reg0;
      1: return reg1;
      2: return reg2;
      default: return reg3;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (d & m) | (old & ~m);
  endfunction

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) chk(tag, dut_reg(i), model[i]);
  endtask

  // AW/W valid raised after their own delays; BREADY held low b_dly cycles.
  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_dly);
    bit aw_done = 1'b0;
    bit w_done = 1'b0;
    int cyc = 0;
    int idx = int'(a[3:2]);
    logic [3:0] exp_p;
    while (!(aw_done && w_done)) begin
      @(negedge aclk);
      if (aw_done) begin
        awvalid = 1'b0;
        chk("awready_after_own_hs", 32'(awready), 32'd0);
      end else if (cyc >= aw_dly) begin
        awvalid = 1'b1;
        awaddr  = a;
      end
      if (w_done) begin
        wvalid = 1'b0;
        chk("wready_after_own_hs", 32'(wready), 32'd0);
      end else if (cyc >= w_dly) begin
        wvalid = 1'b1;
        wdata  = d;
        wstrb  = s;
      end
      if (awvalid && awready) aw_done = 1'b1;
      if (wvalid && wready) w_done = 1'b1;
      cyc++;
      if (cyc > 40) begin
        awvalid = 1'b0;
        wvalid  = 1'b0;
        chk("write_handshake_timeout", 32'd1, 32'd0);
        return;
      end
    end
    @(negedge aclk);
    awvalid = 1'b0;
    wvalid  = 1'b0;
    model[idx] = merge(model[idx], d, s);
    exp_p = 4'b0001 << idx;
    chk("bvalid_after_commit", 32'(bvalid), 32'd1);
    chk("bresp", 32'(bresp), 32'd0);
    chk("wr_pulse", 32'(pulse), 32'(exp_p));
    chk("awready_in_resp", 32'(awready), 32'd0);
    check_regs("reg_after_commit");
    for (int i = 0; i < b_dly; i++) begin
      @(negedge aclk);
      chk("bvalid_hold", 32'(bvalid), 32'd1);
      chk("awready_hold", 32'(awready), 32'd0);
      chk("wready_hold", 32'(wready), 32'd0);
      chk("wr_pulse_one_cycle", 32'(pulse), 32'd0);
    end
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    chk("bvalid_after_b_hs", 32'(bvalid), 32'd0);
    chk("awready_back", 32'(awready), 32'd1);
    chk("wready_back", 32'(wready), 32'd1);
    chk("wr_pulse_cleared", 32'(pulse), 32'd0);
  endtask

  task automatic axi_read(input logic [3:0] a, input int r_dly, input logic [31:0] exp);
    int cyc = 0;
    @(negedge aclk);
    arvalid = 1'b1;
    araddr  = a;
    while (!arready) begin
      @(negedge aclk);
      cyc++;
      if (cyc > 40) begin
        arvalid = 1'b0;
        chk("read_handshake_timeout", 32'd1, 32'd0);
        return;
      end
    end
    @(negedge aclk);
    arvalid = 1'b0;
    chk("rvalid", 32'(rvalid), 32'd1);
    chk("rdata", rdata, exp);
    chk("rresp", 32'(rresp), 32'd0);
    chk("arready_in_data", 32'(arready), 32'd0);
    for (int i = 0; i < r_dly; i++) begin
      @(negedge aclk);
      chk("rvalid_hold", 32'(rvalid), 32'd1);
      chk("rdata_stable", rdata, exp);
      chk("arready_hold", 32'(arready), 32'd0);
    end
    rready = 1'b1;
    @(negedge aclk);
    rready = 1'b0;
    chk("rvalid_after_r_hs", 32'(rvalid), 32'd0);
    chk("arready_back", 32'(arready), 32'd1);
  endtask

  initial begin
    logic [3:0]  ra, rs;
    logic [31:0] rd;
    for (int i = 0; i < 4; i++) model[i] = '0;

    // Reset state
    #12;
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_pulse", 32'(pulse), 32'd0);
    check_regs("rst_reg");
    @(negedge aclk);
    areset = 1'b0;
    #1;
    chk("awready_before_edge", 32'(awready), 32'd0);
    @(negedge aclk);
    chk("awready_first_edge", 32'(awready), 32'd1);
    chk("wready_first_edge", 32'(wready), 32'd1);
    chk("arready_first_edge", 32'(arready), 32'd1);

    // Basic map
    axi_write(4'h0, 32'h1, 4'hF, 0, 0, 0);
    axi_write(4'h4, 32'h2, 4'hF, 0, 0, 0);
    axi_write(4'h8, 32'h3, 4'hF, 0, 0, 0);
    axi_write(4'hC, 32'h4, 4'hF, 0, 0, 0);
    axi_read(4'h0, 0, 32'h1);
    axi_read(4'h4, 0, 32'h2);
    axi_read(4'h8, 0, 32'h3);
    axi_read(4'hC, 0, 32'h4);

    // Byte strobes, including an empty strobe
    axi_write(4'h8, 32'hAABBCCDD, 4'b0010, 0, 0, 0);
    chk("reg2_strobe", reg2, 32'h0000CC03);
    axi_read(4'h8, 0, 32'h0000CC03);
    axi_write(4'hA, 32'h12345678, 4'b0000, 0, 0, 0);
    chk("reg2_zero_strobe", reg2, 32'h0000CC03);

    // AW before W, W before AW
    axi_write(4'hC, 32'hCAFE0001, 4'hF, 0, 3, 0);
    axi_write(4'h0, 32'hCAFE0002, 4'hF, 3, 0, 0);
    axi_read(4'hC, 0, 32'hCAFE0001);
    axi_read(4'h1, 0, 32'hCAFE0002);

    // Backpressure on B and R
    axi_write(4'h0, 32'h0BADF00D, 4'hF, 0, 0, 5);
    axi_read(4'h0, 5, 32'h0BADF00D);

    // Same-edge AR and commit on reg1 (restore reg1 to 0x2 first)
    axi_write(4'h4, 32'h2, 4'hF, 0, 0, 0);
    @(negedge aclk);
    chk("pre_same_awready", 32'(awready), 32'd1);
    chk("pre_same_arready", 32'(arready), 32'd1);
    awvalid = 1'b1; awaddr = 4'h4; wvalid = 1'b1; wdata = 32'h55; wstrb = 4'hF;
    arvalid = 1'b1; araddr = 4'h4;
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("same_edge_rdata_old", rdata, 32'h2);
    chk("same_edge_reg1_new", reg1, 32'h55);
    chk("same_edge_bvalid", 32'(bvalid), 32'd1);
    chk("same_edge_rvalid", 32'(rvalid), 32'd1);
    model[1] = 32'h55;
    bready = 1'b1; rready = 1'b1;
    @(negedge aclk);
    bready = 1'b0; rready = 1'b0;
    chk("same_edge_bvalid_done", 32'(bvalid), 32'd0);
    chk("same_edge_rvalid_done", 32'(rvalid), 32'd0);
    axi_read(4'h4, 0, 32'h55);

    // Reset while B and R are pending
    @(negedge aclk);
    awvalid = 1'b1; awaddr = 4'h0; wvalid = 1'b1; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    arvalid = 1'b1; araddr = 4'h4;
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("pending_bvalid", 32'(bvalid), 32'd1);
    chk("pending_rvalid", 32'(rvalid), 32'd1);
    #2 areset = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) model[i] = '0;
    chk("async_rst_bvalid", 32'(bvalid), 32'd0);
    chk("async_rst_rvalid", 32'(rvalid), 32'd0);
    chk("async_rst_awready", 32'(awready), 32'd0);
    chk("async_rst_arready", 32'(arready), 32'd0);
    chk("async_rst_rdata", rdata, 32'd0);
    chk("async_rst_pulse", 32'(pulse), 32'd0);
    check_regs("async_rst_reg");
    @(negedge aclk);
    @(negedge aclk);
    areset = 1'b0;
    #1;
    chk("rerst_awready_before_edge", 32'(awready), 32'd0);
    @(negedge aclk);
    chk("rerst_awready", 32'(awready), 32'd1);
    chk("rerst_wready", 32'(wready), 32'd1);
    chk("rerst_arready", 32'(arready), 32'd1);
    for (int i = 0; i < 4; i++) axi_read(4'(i * 4), 0, 32'd0);
    axi_write(4'h8, 32'h00C0FFEE, 4'hF, 1, 0, 0);
    axi_read(4'h8, 0, 32'h00C0FFEE);

    // Random traffic against the model
    for (int n = 0; n < 80; n++) begin
      ra = 4'($urandom_range(0, 15));
      rd = $urandom;
      rs = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1)
        axi_write(ra, rd, rs, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 2)));
      else
        axi_read(ra, int'($urandom_range(0, 2)), model[ra[3:2]]);
    end
    check_regs("final_regs");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
